// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the PWM generator and related timers.
package pwm_pkg;

    function automatic int reset_duty(input int res);
        return 1 << (res - 1);
    endfunction

    // Inc and dec together cancel; each direction saturates at its end of the range.
    function automatic int sat_step(input int v, input logic inc, input logic dec, input int max);
        return (inc && !dec) ? ((v >= max) ? max : v + 1) :
               (dec && !inc) ? ((v <= 0) ? 0 : v - 1) : v;
    endfunction

    function automatic int stagger_off(input int i, input int res, input int ch);
        return i * ((1 << res) / ch);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: one tick every div+1 clk while en; div is re-latched at each wrap.
module pwm_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt;
    logic [DIV_W-1:0] div_l;

    assign tick = en && (pcnt == div_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            div_l <= '0;
        end else if (!en || tick) begin
            pcnt  <= '0;
            div_l <= div;
        end else begin
            pcnt  <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM with shadowed duty committed at period start.
// Define PWM_PHASE_STAGGER_EN to interleave channel edges evenly across the period.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH    = 4,
    parameter int RES   = 8,
    parameter int DIV_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [CH*RES-1:0] duty,
    input  logic [CH-1:0]     duty_load,
    input  logic [CH-1:0]     duty_inc,
    input  logic [CH-1:0]     duty_dec,
    output logic [CH-1:0]     pwm_out,
    output logic              period_tick,
    output logic [CH*RES-1:0] duty_q
);

    localparam logic [RES-1:0] RST_DUTY = RES'(reset_duty(RES));
    localparam int MAX_DUTY = (1 << RES) - 1;

    logic           tick;
    logic [RES-1:0] cnt;
    logic           start;

    pwm_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .tick (tick)
    );

    // Period start is the tick that compares count 0; commit and period_tick land on it.
    assign start = tick && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else if (!en) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= start;
            if (tick) cnt <= cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [RES-1:0] sh;
        logic [RES-1:0] act;
        logic [RES-1:0] nxt_act;
        logic [RES-1:0] cnt_ch;
        logic           pwm_r;
`ifdef PWM_PHASE_STAGGER_EN
        assign cnt_ch = cnt + RES'(stagger_off(g, RES, CH));
`else
        assign cnt_ch = cnt;
`endif
        // The count-0 compare already uses the newly committed duty.
        assign nxt_act = start ? sh : act;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh    <= RST_DUTY;
                act   <= RST_DUTY;
                pwm_r <= 1'b0;
            end else begin
                sh <= duty_load[g] ? duty[g*RES +: RES]
                                   : RES'(sat_step(int'(sh), duty_inc[g], duty_dec[g], MAX_DUTY));
                if (!en) begin
                    act   <= sh;
                    pwm_r <= 1'b0;
                end else if (tick) begin
                    act   <= nxt_act;
                    pwm_r <= cnt_ch < nxt_act;
                end
            end
        end
        assign pwm_out[g]           = pwm_r;
        assign duty_q[g*RES +: RES] = act;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator that succeeds the single-channel 3-bit PWM block in the motor/heater drive path. A shared prescaler and period counter drive CH independent duty comparators. Each channel has a shadow duty register that is committed only at the period boundary, so duty changes never glitch the output. Per-channel saturating increment/decrement controls are provided for closed-loop trimming.

## Interface
- CH, 4, number of PWM channels (1..16)
- RES, 8, counter/duty resolution in bits; period = 2^RES counts
- DIV_W, 4, prescaler select width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable
- div  in  DIV_W  prescaler; one count tick every div+1 clk cycles
- duty  in  CH*RES  load value per channel; channel i = duty[i*RES +: RES]
- duty_load  in  CH  per-channel pulse; captures the duty slice into that channel's shadow
- duty_inc  in  CH  per-channel shadow increment request
- duty_dec  in  CH  per-channel shadow decrement request
- pwm_out  out  CH  PWM outputs, registered
- period_tick  out  1  one-clk pulse at each period start
- duty_q  out  CH*RES  active (committed) duty per channel

## Operation
- Prescaler: counts clk while en=1. It asserts the internal tick every div+1 cycles, so div=0 gives a tick on every cycle. A change to div takes effect at the next prescaler wrap.
- Period counter cnt (RES bits): increments on tick and wraps from 2^RES-1 to 0.
- Boundary event: the cycle in which cnt wraps to 0. On that edge:
  - active duty <= shadow duty for all channels;
  - period_tick = 1 for that one clk.
- Shadow update, per channel, evaluated every clk with priority load > inc/dec:
  - duty_load[i]=1: shadow <= duty slice, and inc/dec for that channel is ignored that cycle.
  - inc and dec both 1: no change.
  - inc only: shadow+1, saturating at 2^RES-1.
  - dec only: shadow-1, saturating at 0.
- Comparison: pwm_out[i] <= (cnt_ch[i] < active[i]), evaluated on tick. cnt_ch is described under Configuration.
  - duty 0 gives constant low.
  - duty 2^RES-1 gives high for 2^RES-1 of 2^RES counts.
- en=0:
  - prescaler and cnt cleared to 0;
  - pwm_out = 0 and period_tick = 0 on the next edge;
  - active duty tracks shadow every cycle, so the first period after re-enable uses the latest shadow.
  - Shadow load, inc and dec remain functional.
- Reset values:
  - cnt, prescaler, pwm_out and period_tick are 0;
  - shadow and active duty are 2^(RES-1) (50%) for every channel;
  - duty_q reflects the reset active value.
- Reset asserted mid-period returns all of the above immediately (asynchronous reset). No partial period is completed.

## Timing
- Output latency: pwm_out changes on the same clk edge that advances cnt, using the pre-increment count.
- duty_load to effect: the shadow is visible 1 clk after the load pulse. The active value and the output take effect at the next boundary, at most 2^RES*(div+1) clk later.
- Load in the same clk as the boundary edge: the old shadow commits. The new value commits at the following boundary.
- duty_q updates on the boundary edge, simultaneously with period_tick.
- The first tick after en rises occurs div+1 clk later. That tick produces count 0 with period_tick=1.

## Configuration
- PWM_PHASE_STAGGER_EN defined: cnt_ch[i] = (cnt + i*(2^RES/CH)) mod 2^RES. Channel edges are evenly interleaved to reduce supply ripple. The boundary commit and period_tick still follow the global cnt.
- Not defined: cnt_ch[i] = cnt for all channels, and all rising edges are aligned at count 0.

## Structure
- Shared package pwm_pkg holds:
  - the reset-duty constant function (2^(RES-1));
  - the saturating inc/dec helper function;
  - the stagger offset function.
- Sub-module pwm_prescaler holds the div counter and tick generation, cleared by en=0. It is reused by other timer blocks.
- Per-channel shadow, active and compare logic is a generate loop inside pwm_multi, not a separate module.

## Test plan
- Reset defaults: CH=4, RES=8, div=0, en=1 after reset, so duty_q = 128 for every channel. Required: each pwm_out high 128 of 256 cycles, and period_tick every 256 clk.
- Shadow commit: load duty=64 on ch0 mid-period. Required: ch0 output stays at 128-high until the boundary, then 64-high. duty_q[0] changes exactly with period_tick.
- Saturation and priority:
  - shadow 254 with inc pulsed 3 times: duty_q goes to 255 at the next boundary;
  - inc+dec together: no change;
  - load(10) with inc in the same cycle: commits 10.
- Extremes and prescaler: duty 0 with div=3 gives constant low. Duty 255 gives low for exactly 4 clk per 1024-clk period.
- Enable/reset mid-period:
  - drop en at cnt=100: outputs go low next edge, and restart at count 0 after div+1 clk;
  - assert rst at cnt=50: everything returns to reset values asynchronously.
- With PWM_PHASE_STAGGER_EN and all duties at 64: the rising edges of ch0..ch3 occur 64 ticks apart.
